// File: rtl/int_to_float_converter.sv
// Purpose: iterative 32-bit integer to IEEE-754 single conversion, round to nearest, ties to even.
// Latency: L+2 edges after acceptance (L = leading zeros of the magnitude); zero operand needs 0 extra edges.
// Backpressure: one operand in flight; the result is held in OUT until out_ready, and in_ready is high only in IDLE.
module int_to_float_converter #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [7:0] EXP_TOP = 8'd158;  // bias 127 plus 31: value of bit 31

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] out_q, out_d;

  logic        in_neg;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_sum;

  // Rounding terms from the normalized magnitude; bit 31 is the hidden one.
  assign in_neg   = SIGNED & in_data[31];
  assign guard    = mag_q[7];
  assign sticky   = |mag_q[6:0];
  assign round_up = guard & (sticky | mag_q[8]);
  assign mant_sum = {1'b0, mag_q[30:8]} + {23'd0, round_up};

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= 32'd0;
      exp_q   <= 8'd0;
      out_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      out_q   <= out_d;
    end
  end

  // Next-state and datapath updates: accept, shift left until bit 31 is set, round, hold.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_data == 32'd0) begin
            out_d   = 32'd0;
            state_d = OUT;
          end else begin
            sign_d  = in_neg;
            mag_d   = in_neg ? (32'd0 - in_data) : in_data;
            exp_d   = EXP_TOP;
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      ROUND: begin
        // A carry out of the mantissa leaves its low 23 bits at zero and bumps the exponent.
        out_d   = {sign_q, exp_q + {7'd0, mant_sum[23]}, mant_sum[22:0]};
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_int_to_float_converter.sv
// Bench for int_to_float_converter: directed vectors, handshake and reset sequences,
// and random operands against an arithmetic rounding model, on a signed and an unsigned instance.
module tb_int_to_float_converter;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        vld_s, vld_u;
  logic        rdy_s, rdy_u;
  logic        ordy_s, ordy_u;
  logic        ov_s, ov_u;
  logic [31:0] od_s, od_u;
  logic        busy_s, busy_u;

  int n_checks;
  int n_fail;

  int_to_float_converter #(.SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(vld_s), .in_ready(rdy_s), .in_data(in_data),
    .out_valid(ov_s), .out_ready(ordy_s), .out_data(od_s),
    .busy(busy_s)
  );

  int_to_float_converter #(.SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst),
    .in_valid(vld_u), .in_ready(rdy_u), .in_data(in_data),
    .out_valid(ov_u), .out_ready(ordy_u), .out_data(od_u),
    .busy(busy_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] din;
    logic [31:0] exp_out;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: pick the top set bit, keep 24 significant bits, round the discarded remainder.
  function automatic logic [31:0] ref_conv(input bit sgn, input logic [31:0] d);
    bit              s;
    longint unsigned m, q, rem, half;
    int              p, e, sh;
    if (d == 32'd0) return 32'd0;
    s = sgn && d[31];
    m = s ? ((64'd1 << 32) - {32'd0, d}) : {32'd0, d};
    p = 0;
    for (int i = 0; i < 33; i++) if (m >= (64'd1 << i)) p = i;
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic int ref_lat(input bit sgn, input logic [31:0] d);
    longint unsigned m;
    int p;
    if (d == 32'd0) return 0;
    m = (sgn && d[31]) ? ((64'd1 << 32) - {32'd0, d}) : {32'd0, d};
    p = 0;
    for (int i = 0; i < 32; i++) if (m >= (64'd1 << i)) p = i;
    return (31 - p) + 2;
  endfunction

  function automatic logic f_ov(input bit sgn);
    return sgn ? ov_s : ov_u;
  endfunction

  function automatic logic [31:0] f_od(input bit sgn);
    return sgn ? od_s : od_u;
  endfunction

  function automatic logic f_rdy(input bit sgn);
    return sgn ? rdy_s : rdy_u;
  endfunction

  function automatic logic f_busy(input bit sgn);
    return sgn ? busy_s : busy_u;
  endfunction

  // Called #1 after a rising edge with the chosen instance idle.
  task automatic run_op(input bit sgn, input logic [31:0] d, input bit release_out,
                        output logic [31:0] res, output int lat);
    in_data = d;
    if (sgn) vld_s = 1'b1; else vld_u = 1'b1;
    @(posedge clk); #1;
    vld_s   = 1'b0;
    vld_u   = 1'b0;
    in_data = $urandom;  // must not disturb the operand already captured
    lat = 0;
    while (!f_ov(sgn) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = f_od(sgn);
    if (release_out) begin
      if (sgn) ordy_s = 1'b1; else ordy_u = 1'b1;
      @(posedge clk); #1;
      ordy_s = 1'b0;
      ordy_u = 1'b0;
    end
  endtask

  vec_t        vecs[$];
  logic [31:0] res;
  int          lat;
  logic [31:0] held;
  logic [31:0] d;
  bit          sgn;
  string       nm;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vld_s = 1'b0; vld_u = 1'b0;
    ordy_s = 1'b0; ordy_u = 1'b0;
    in_data = 32'd0;
    rst = 1'b0;

    vecs.push_back('{1'b1, 32'h00000001, 32'h3F800000, 33});
    vecs.push_back('{1'b1, 32'hFFFFFFFF, 32'hBF800000, 33});
    vecs.push_back('{1'b1, 32'h80000000, 32'hCF000000, 2});
    vecs.push_back('{1'b0, 32'h80000000, 32'h4F000000, 2});
    vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'h4F800000, 2});
    vecs.push_back('{1'b1, 32'h7FFFFFFF, 32'h4F000000, 3});
    vecs.push_back('{1'b1, 32'h01000001, 32'h4B800000, 9});
    vecs.push_back('{1'b1, 32'h01000003, 32'h4B800002, 9});
    vecs.push_back('{1'b1, 32'h00000000, 32'h00000000, 0});
    vecs.push_back('{1'b0, 32'h00000000, 32'h00000000, 0});
    vecs.push_back('{1'b1, 32'h00000003, 32'h40400000, 32});

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", {31'd0, rdy_s}, 32'd1);
    check("reset out_valid", {31'd0, ov_s}, 32'd0);
    check("reset out_data", od_s, 32'd0);
    check("reset busy", {31'd0, busy_s}, 32'd0);
    check("reset in_ready unsigned", {31'd0, rdy_u}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].din, 1'b1, res, lat);
      nm = $sformatf("vec%0d data 0x%08h", i, vecs[i].din);
      check(nm, res, vecs[i].exp_out);
      nm = $sformatf("vec%0d latency", i);
      check(nm, 32'(lat), 32'(vecs[i].exp_lat));
      check("idle after transfer", {31'd0, f_rdy(vecs[i].sgn)}, 32'd1);
    end

    // Back-pressure: result held for 10 cycles with out_ready low
    run_op(1'b1, 32'd5, 1'b0, res, lat);
    check("bp data", res, 32'h40A00000);
    held = res;
    vld_s = 1'b1;  // offered input must be ignored while in OUT
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp out_valid", {31'd0, ov_s}, 32'd1);
      check("bp out_data", od_s, held);
      check("bp in_ready", {31'd0, rdy_s}, 32'd0);
    end
    vld_s  = 1'b0;
    ordy_s = 1'b1;
    check("bp in_ready with out_ready", {31'd0, rdy_s}, 32'd0);
    @(posedge clk); #1;
    ordy_s = 1'b0;
    check("bp release in_ready", {31'd0, rdy_s}, 32'd1);
    check("bp release out_valid", {31'd0, ov_s}, 32'd0);

    // Reset in the middle of normalization
    in_data = 32'd1;
    vld_s   = 1'b1;
    @(posedge clk); #1;
    vld_s = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid busy before reset", {31'd0, busy_s}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort in_ready", {31'd0, rdy_s}, 32'd1);
    check("abort out_valid", {31'd0, ov_s}, 32'd0);
    check("abort busy", {31'd0, busy_s}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, 32'd3, 1'b1, res, lat);
    check("after abort data", res, 32'h40400000);
    check("after abort latency", 32'(lat), 32'd32);

    // Random operands against the model
    for (int k = 0; k < 300; k++) begin
      sgn = k[0];
      d   = $urandom;
      case ($urandom_range(0, 3))
        0: d = d >> $urandom_range(0, 31);
        1: d = d & 32'hFFFFFF80;
        2: d = {1'b1, d[30:0]};
        default: ;
      endcase
      run_op(sgn, d, 1'b1, res, lat);
      nm = $sformatf("rand sgn=%0d in=0x%08h", sgn, d);
      check(nm, res, ref_conv(sgn, d));
      nm = $sformatf("rand latency in=0x%08h", d);
      check(nm, 32'(lat), 32'(ref_lat(sgn, d)));
    end

    check("final idle busy", {31'd0, f_busy(1'b0)}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
